// File: rtl/bcd_counter_pkg.sv
// Shared types and helpers for the cascaded BCD counter: the decade digit type,
// its maximum code, and integer-to-packed-BCD conversion for reset constants.
package bcd_counter_pkg;

    typedef logic [3:0] digit_t;

    localparam digit_t DIGIT_MAX = 4'd9;

    // Eight decades cover the largest supported counter; callers take the low slice.
    function automatic logic [31:0] bcd_from_int(input int unsigned value);
        logic [31:0] result;
        int unsigned v;
        result = '0;
        v = value;
        for (int i = 0; i < 8; i++) begin
            result[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: clear, clamped parallel load, and wrapping up/down step.
// Flags at_max/at_zero feed the ripple-enable chain in the parent counter.
module bcd_digit
    import bcd_counter_pkg::*;
#(
    parameter digit_t RESET_DIGIT = '0
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   step,
    input  logic   up_dn,
    input  logic   clr,
    input  logic   load,
    input  digit_t load_digit,
    output digit_t digit,
    output logic   at_max,
    output logic   at_zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit <= RESET_DIGIT;
        end else if (clr) begin
            digit <= '0;
        end else if (load) begin
            // Non-decimal codes saturate so the digit never leaves 0..9.
            digit <= (load_digit > DIGIT_MAX) ? DIGIT_MAX : load_digit;
        end else if (step) begin
            if (up_dn) begin
                digit <= (digit == DIGIT_MAX) ? '0 : digit + 4'd1;
            end else begin
                digit <= (digit == '0) ? DIGIT_MAX : digit - 4'd1;
            end
        end
    end

    assign at_max  = (digit == DIGIT_MAX);
    assign at_zero = (digit == '0);

endmodule

// File: rtl/bcd_counter.sv
// Cascaded NUM_DIGITS-decade BCD up/down counter with terminal-count output.
// Define BCD_COUNTER_LOAD_EN to add the load/load_val parallel-load ports.
module bcd_counter
    import bcd_counter_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int RESET_VAL  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    up_dn,
`ifdef BCD_COUNTER_LOAD_EN
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
`endif
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    tc
);

    localparam logic [31:0] RESET_BCD = bcd_from_int(RESET_VAL);

    logic [NUM_DIGITS:0]   up_chain;
    logic [NUM_DIGITS:0]   dn_chain;
    logic [NUM_DIGITS-1:0] at_max;
    logic [NUM_DIGITS-1:0] at_zero;
    logic [NUM_DIGITS-1:0] step;
    logic                  load_i;
    logic [4*NUM_DIGITS-1:0] load_val_i;

`ifdef BCD_COUNTER_LOAD_EN
    assign load_i     = load;
    assign load_val_i = load_val;
`else
    assign load_i     = 1'b0;
    assign load_val_i = '0;
`endif

    // Chain bit i is high when every lower decade is at its wrap value.
    assign up_chain[0] = en & up_dn;
    assign dn_chain[0] = en & ~up_dn;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        assign up_chain[i+1] = up_chain[i] & at_max[i];
        assign dn_chain[i+1] = dn_chain[i] & at_zero[i];
        assign step[i]       = up_chain[i] | dn_chain[i];

        bcd_digit #(
            .RESET_DIGIT(RESET_BCD[4*i +: 4])
        ) u_digit (
            .clk       (clk),
            .rst       (rst),
            .step      (step[i]),
            .up_dn     (up_dn),
            .clr       (clr),
            .load      (load_i),
            .load_digit(load_val_i[4*i +: 4]),
            .digit     (count[4*i +: 4]),
            .at_max    (at_max[i]),
            .at_zero   (at_zero[i])
        );
    end

    // tc is held low during reset so a downstream cascade never sees a spurious carry.
`ifdef BCD_COUNTER_LOAD_EN
    assign tc = ~rst & ~clr & ~load_i & (up_chain[NUM_DIGITS] | dn_chain[NUM_DIGITS]);
`else
    assign tc = ~rst & ~clr & (up_chain[NUM_DIGITS] | dn_chain[NUM_DIGITS]);
`endif

endmodule

// File: doc/bcd_counter.md
BCD_COUNTER -- requirements
Module: bcd_counter

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of cascaded BCD decades (1..8).
REQ-002 Parameter RESET_VAL, default 0, power-on and reset count as an integer (must be < 10^NUM_DIGITS).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 clr  input  1  synchronous clear to all-zero digits.
REQ-006 en  input  1  count enable; one step per enabled cycle.
REQ-007 up_dn  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 load  input  1  synchronous parallel load (present only with BCD_COUNTER_LOAD_EN).
REQ-009 load_val  input  4*NUM_DIGITS  packed BCD load value, digit 0 in bits [3:0] (present only with BCD_COUNTER_LOAD_EN).
REQ-010 count  output  4*NUM_DIGITS  packed BCD count, digit 0 least significant.
REQ-011 tc  output  1  terminal-count flag, combinational.

Function
REQ-012 Each nibble of count SHALL always hold 0..9; no other code may be reached from any input sequence.
REQ-013 Per-cycle priority SHALL be: rst > clr > load > en; no change when none is active.
REQ-014 clr SHALL set all digits to 0 on the next edge, regardless of en, up_dn or load.
REQ-015 Up count: digit i SHALL step only when en=1, up_dn=1 and digits 0..i-1 all equal 9.
REQ-016 Up count: a stepping digit at 9 SHALL wrap to 0; other stepping digits SHALL add 1.
REQ-017 Down count: digit i SHALL step only when en=1, up_dn=0 and digits 0..i-1 all equal 0.
REQ-018 Down count: a stepping digit at 0 SHALL wrap to 9; other stepping digits SHALL subtract 1.
REQ-019 All-9s counting up SHALL wrap to all-0s, and all-0s counting down SHALL wrap to all-9s, in one cycle.
REQ-020 tc SHALL be 1 iff en=1, clr=0, load=0 and the count is all-9s with up_dn=1 or all-0s with up_dn=0.
REQ-021 tc SHALL assert in the cycle before the wrap edge, enabling external cascading of multiple instances via en.
REQ-022 Changing up_dn between enabled cycles SHALL take effect immediately, with no penalty cycle.
REQ-023 Latency from the qualifying input edge to the count update SHALL be one clock.

Reset
REQ-024 While rst=1, count SHALL equal the BCD encoding of RESET_VAL, and tc SHALL be 0.
REQ-025 Reset asserted mid-count SHALL abandon the step immediately; counting SHALL resume on the first enabled edge after rst is released.

Configuration
REQ-026 With BCD_COUNTER_LOAD_EN defined, load=1 SHALL write load_val into count on the next edge, overriding en.
REQ-027 With BCD_COUNTER_LOAD_EN defined, any load_val nibble greater than 9 SHALL be loaded as 9.
REQ-028 With BCD_COUNTER_LOAD_EN undefined, the load and load_val ports SHALL be absent and the load-related tc terms SHALL be removed.

Structure
REQ-029 Package bcd_counter_pkg SHALL hold the digit typedef (4-bit), the DIGIT_MAX constant (9) and a function that converts an integer to packed BCD (used for RESET_VAL).
REQ-030 Sub-module bcd_digit SHALL implement one decade: inputs step, up_dn, clr, load and load digit; outputs the digit value plus at_max and at_zero flags.
REQ-031 bcd_counter SHALL instantiate NUM_DIGITS copies of bcd_digit in a generate loop and build the ripple-enable chain combinationally.

Verification (NUM_DIGITS=2, RESET_VAL=0 unless stated)
REQ-032 rst pulse, then en=1 and up_dn=1 for 100 cycles -> count 00,01..99,00; tc high only in the cycle count=99.
REQ-033 count=00, en=1, up_dn=0 for 3 cycles -> count 99, 98, 97; tc high in the first cycle.
REQ-034 count=37 with clr=1, load=1 and en=1 in the same cycle -> count 00 next cycle; tc=0.
REQ-035 With BCD_COUNTER_LOAD_EN, load load_val=0x5C -> count 59; a following up step gives 60.
REQ-036 rst asserted asynchronously mid-cycle at count=45 -> count returns to 00 before the next edge; with RESET_VAL=42, the reset value is 42.
REQ-037 Random en, up_dn and clr for 10k cycles vs an integer reference model mod 100 -> exact match; every nibble stays ≤9.
